controlador_display_temperatura: RTL

Controller that sequences the temperature BCD conversion path and shares one 4-digit common-anode 7-segment display between the digits it produces. It periodically requests a new sample and latches the BCD tens/units on a valid handshake. It time-multiplexes four digits: tens, units, degree symbol, 'C'. It sits between the BCD converter output and the board display pins.

---
 rtl/controlador_display_temperatura.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/controlador_display_temperatura.sv
// Temperature display controller: requests BCD samples from the converter,
// holds the last good reading and scans it onto a 4-digit common-anode
// 7-segment display as [tens][units][degree]['C'].
module controlador_display_temperatura #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned SAMPLE_DIV  = 50000000,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] decenas_in,
    input  logic [3:0] unidades_in,
    input  logic       dato_valido,
    output logic       solicitud,
    output logic [3:0] anodos,
    output logic [6:0] segmentos,
    output logic       error
);

    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SMP_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [6:0] SEG_DASH   = 7'b0111111;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_DEGREE = 7'b0011100;
    localparam logic [6:0] SEG_C      = 7'b1000110;

    typedef enum logic {
        ESPERA,
        SOLICITA
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [PRE_W-1:0]   r_pre;
    logic [1:0]         r_idx;
    logic [SMP_W-1:0]   r_timer;
    logic [TO_W-1:0]    r_to;
    logic [3:0]         r_tens;
    logic [3:0]         r_units;
    logic               r_held_ok;
    logic               r_error;
    logic [3:0]         r_anodos;
    logic [6:0]         r_seg;
    logic               w_sample_tc;
    logic               w_capture;
    logic               w_timeout;
    logic               w_solicitud;
    logic               w_pre_wrap;
    logic [6:0]         w_seg;

    // Active-low 7-segment pattern for a BCD digit; non-decimal codes show a dash.
    function automatic logic [6:0] bcd7(input logic [3:0] d);
        case (d)
            4'd0:    bcd7 = 7'b1000000;
            4'd1:    bcd7 = 7'b1111001;
            4'd2:    bcd7 = 7'b0100100;
            4'd3:    bcd7 = 7'b0110000;
            4'd4:    bcd7 = 7'b0011001;
            4'd5:    bcd7 = 7'b0010010;
            4'd6:    bcd7 = 7'b0000010;
            4'd7:    bcd7 = 7'b1111000;
            4'd8:    bcd7 = 7'b0000000;
            4'd9:    bcd7 = 7'b0010000;
            default: bcd7 = SEG_DASH;
        endcase
    endfunction

    assign w_sample_tc = (r_timer == SMP_W'(SAMPLE_DIV - 1));
    assign w_pre_wrap  = (r_pre == PRE_W'(REFRESH_DIV - 1));

    // Sample FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ESPERA;
        else       r_state <= w_next_state;
    end

    // Sample FSM next state; a capture takes priority over a same-cycle timeout.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ESPERA: begin
                if (w_sample_tc) w_next_state = SOLICITA;
            end
            SOLICITA: begin
                if (dato_valido) begin
                    w_capture    = 1'b1;
                    w_next_state = ESPERA;
                end else if (r_to == TO_W'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_next_state = ESPERA;
                end
            end
            default: w_next_state = ESPERA;
        endcase
    end

    // Sample FSM outputs.
    always_comb begin
        w_solicitud = 1'b0;
        if (r_state == SOLICITA) w_solicitud = 1'b1;
    end

    // Sample timer (ESPERA only) and request timeout counter (SOLICITA only).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
            r_to    <= '0;
        end else begin
            if (r_state == ESPERA && !w_sample_tc) r_timer <= r_timer + SMP_W'(1);
            else                                   r_timer <= '0;
            if (r_state == SOLICITA && w_next_state == SOLICITA) r_to <= r_to + TO_W'(1);
            else                                                 r_to <= '0;
        end
    end

    // Held reading and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tens    <= '0;
            r_units   <= '0;
            r_held_ok <= 1'b0;
            r_error   <= 1'b0;
        end else if (w_capture) begin
            r_tens    <= decenas_in;
            r_units   <= unidades_in;
            r_held_ok <= 1'b1;
            r_error   <= 1'b0;
        end else if (w_timeout) begin
            r_error   <= 1'b1;
        end
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_pre_wrap) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        w_seg = SEG_BLANK;
        case (r_idx)
            2'd3: begin
                if (!r_held_ok || r_error || r_tens > 4'd9) w_seg = SEG_DASH;
                else if (r_tens == 4'd0)                    w_seg = SEG_BLANK;
                else                                        w_seg = bcd7(r_tens);
            end
            2'd2: begin
                if (!r_held_ok || r_error || r_units > 4'd9) w_seg = SEG_DASH;
                else                                         w_seg = bcd7(r_units);
            end
            2'd1:    w_seg = SEG_DEGREE;
            default: w_seg = SEG_C;
        endcase
    end

    // Registered display pins, one cycle behind the scan index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_anodos <= '1;
            r_seg    <= '1;
        end else begin
            r_anodos <= ~(4'b0001 << r_idx);
            r_seg    <= w_seg;
        end
    end

    assign solicitud = w_solicitud;
    assign anodos    = r_anodos;
    assign segmentos = r_seg;
    assign error     = r_error;

endmodule
